// File: rtl/buzzer_scheduler_if.sv
// buzzer_scheduler_if
// Groups the alert request pulses and the buzzer outputs of buzzer_scheduler.
//   req_key    : 1-cycle pulse, request key click
//   req_open   : 1-cycle pulse, request door-open chime
//   req_freeze : 1-cycle pulse, request freeze alarm
//   BUZZER     : square-wave drive to the piezo
//   busy       : high while a pattern plays or the trailing gap runs
//   active_src : 00 none, 01 key, 10 open, 11 freeze (valid while playing)
//   done       : 1-cycle pulse when a pattern finishes normally
// master = requester side, slave = scheduler side.
interface buzzer_scheduler_if;
    logic       req_key;
    logic       req_open;
    logic       req_freeze;
    logic       BUZZER;
    logic       busy;
    logic [1:0] active_src;
    logic       done;

    modport master (
        output req_key,
        output req_open,
        output req_freeze,
        input  BUZZER,
        input  busy,
        input  active_src,
        input  done
    );

    modport slave (
        input  req_key,
        input  req_open,
        input  req_freeze,
        output BUZZER,
        output busy,
        output active_src,
        output done
    );
endinterface

// File: rtl/buzzer_scheduler.sv
// buzzer_scheduler
// Shares one piezo between three alert sources (key click, door-open chime,
// freeze alarm). Request pulses are latched as pending flags and granted by
// fixed priority freeze > open > key; each granted source plays as a list of
// square-wave notes, followed by a silent gap.
// Ports:
//   CLK   : system clock
//   RESET : asynchronous reset, active-low
//   bus   : buzzer_scheduler_if.slave (req_* in; BUZZER, busy, active_src, done out)
// Build option:
//   BUZZER_PREEMPT_EN - when defined, a pending higher-priority source aborts
//   the playing pattern and starts immediately (no done pulse, no gap).
module buzzer_scheduler #(
    parameter int CLK_HZ       = 24000000,
    parameter int HI_HZ        = 2000,
    parameter int LO_HZ        = 1000,
    parameter int KEY_MS       = 30,
    parameter int OPEN_NOTE_MS = 150,
    parameter int ALARM_MS     = 200,
    parameter int ALARM_PAIRS  = 5,
    parameter int GAP_MS       = 20
) (
    input  logic              CLK,
    input  logic              RESET,
    buzzer_scheduler_if.slave bus
);
    localparam int MS           = CLK_HZ / 1000;
    localparam int HALF_HI      = CLK_HZ / (2 * HI_HZ);
    localparam int HALF_LO      = CLK_HZ / (2 * LO_HZ);
    localparam int FREEZE_NOTES = 2 * ALARM_PAIRS;
    localparam int MAX_LEN_A    = (KEY_MS > OPEN_NOTE_MS) ? KEY_MS : OPEN_NOTE_MS;
    localparam int MAX_LEN_B    = (ALARM_MS > GAP_MS) ? ALARM_MS : GAP_MS;
    localparam int MAX_LEN      = (MAX_LEN_A > MAX_LEN_B) ? MAX_LEN_A : MAX_LEN_B;
    localparam int MAX_HALF     = (HALF_HI > HALF_LO) ? HALF_HI : HALF_LO;

    // Counters only ever hold 0..N-1 before being reloaded, so $clog2(N) bits.
    localparam int MS_W   = (MS > 1) ? $clog2(MS) : 1;
    localparam int LEN_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int HALF_W = (MAX_HALF > 1) ? $clog2(MAX_HALF) : 1;
    localparam int IDX_W  = (FREEZE_NOTES > 1) ? $clog2(FREEZE_NOTES) : 1;

    // Source codes double as priority: a larger code wins.
    localparam logic [1:0] SRC_NONE   = 2'd0;
    localparam logic [1:0] SRC_KEY    = 2'd1;
    localparam logic [1:0] SRC_OPEN   = 2'd2;
    localparam logic [1:0] SRC_FREEZE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_reg,    state_next;
    logic [1:0]        src_reg,      src_next;
    logic [2:0]        pend_reg,     pend_next;
    logic [IDX_W-1:0]  note_idx_reg, note_idx_next;
    logic [MS_W-1:0]   ms_cnt_reg,   ms_cnt_next;
    logic [LEN_W-1:0]  ms_num_reg,   ms_num_next;
    logic [HALF_W-1:0] half_cnt_reg, half_cnt_next;
    logic              buzzer_reg,   buzzer_next;
    logic              done_reg,     done_next;

    logic [2:0]        req_vec;
    logic [1:0]        grant_src;
    logic              take;
    logic              preempt;
    logic [LEN_W-1:0]  note_last_ms;
    logic [LEN_W-1:0]  cur_last_ms;
    logic [IDX_W-1:0]  last_note;
    logic              note_hi;
    logic [HALF_W-1:0] half_last;
    logic              ms_tick;
    logic              half_tick;
    logic              period_end;

    // Bit i of req_vec/pend_reg belongs to source code i+1.
    assign req_vec = {bus.req_freeze, bus.req_open, bus.req_key};

    // Highest-priority pending source.
    always_comb begin
        grant_src = SRC_NONE;
        if (pend_reg[2]) begin
            grant_src = SRC_FREEZE;
        end else if (pend_reg[1]) begin
            grant_src = SRC_OPEN;
        end else if (pend_reg[0]) begin
            grant_src = SRC_KEY;
        end
    end

    // A fresh request wins over the grant clearing the same flag, so a source
    // re-requested in its grant cycle still replays. Repeats simply merge.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pend
            assign pend_next[gi] = (pend_reg[gi] & ~(take & (grant_src == 2'(gi + 1))))
                                   | req_vec[gi];
        end
    endgenerate

`ifdef BUZZER_PREEMPT_EN
    assign preempt = (state_reg == PLAY) && (grant_src > src_reg);
`else
    assign preempt = 1'b0;
`endif

    // Note list of the playing source: length (ms-1), last index, and pitch.
    always_comb begin
        note_last_ms = LEN_W'(KEY_MS - 1);
        last_note    = '0;
        note_hi      = 1'b1;
        case (src_reg)
            SRC_OPEN: begin
                note_last_ms = LEN_W'(OPEN_NOTE_MS - 1);
                last_note    = IDX_W'(1);
                note_hi      = note_idx_reg[0];      // LO then HI
            end
            SRC_FREEZE: begin
                note_last_ms = LEN_W'(ALARM_MS - 1);
                last_note    = IDX_W'(FREEZE_NOTES - 1);
                note_hi      = ~note_idx_reg[0];     // HI, LO, HI, LO ...
            end
            default: ;
        endcase
    end

    assign half_last   = note_hi ? HALF_W'(HALF_HI - 1) : HALF_W'(HALF_LO - 1);
    assign cur_last_ms = (state_reg == GAP) ? LEN_W'(GAP_MS - 1) : note_last_ms;
    assign ms_tick     = (ms_cnt_reg == MS_W'(MS - 1));
    assign half_tick   = (half_cnt_reg == half_last);
    assign period_end  = ms_tick && (ms_num_reg == cur_last_ms);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg    <= IDLE;
            src_reg      <= SRC_NONE;
            pend_reg     <= '0;
            note_idx_reg <= '0;
            ms_cnt_reg   <= '0;
            ms_num_reg   <= '0;
            half_cnt_reg <= '0;
            buzzer_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            src_reg      <= src_next;
            pend_reg     <= pend_next;
            note_idx_reg <= note_idx_next;
            ms_cnt_reg   <= ms_cnt_next;
            ms_num_reg   <= ms_num_next;
            half_cnt_reg <= half_cnt_next;
            buzzer_reg   <= buzzer_next;
            done_reg     <= done_next;
        end
    end

    // Timers and the tone default to cleared so every note and gap starts
    // from zero with a silent buzzer; only PLAY/GAP advance them.
    always_comb begin
        state_next    = state_reg;
        src_next      = src_reg;
        note_idx_next = note_idx_reg;
        ms_cnt_next   = '0;
        ms_num_next   = '0;
        half_cnt_next = '0;
        buzzer_next   = 1'b0;
        done_next     = 1'b0;
        take          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (grant_src != SRC_NONE) begin
                    take          = 1'b1;
                    src_next      = grant_src;
                    note_idx_next = '0;
                    state_next    = PLAY;
                end
            end

            PLAY: begin
                ms_cnt_next   = ms_tick ? '0 : ms_cnt_reg + MS_W'(1);
                ms_num_next   = ms_tick ? ms_num_reg + LEN_W'(1) : ms_num_reg;
                half_cnt_next = half_tick ? '0 : half_cnt_reg + HALF_W'(1);
                buzzer_next   = half_tick ? ~buzzer_reg : buzzer_reg;

                if (preempt) begin
                    // Aborted pattern is dropped; new one starts from note 0.
                    take          = 1'b1;
                    src_next      = grant_src;
                    note_idx_next = '0;
                    ms_cnt_next   = '0;
                    ms_num_next   = '0;
                    half_cnt_next = '0;
                    buzzer_next   = 1'b0;
                end else if (period_end) begin
                    ms_cnt_next   = '0;
                    ms_num_next   = '0;
                    half_cnt_next = '0;
                    buzzer_next   = 1'b0;
                    if (note_idx_reg == last_note) begin
                        state_next = GAP;
                        done_next  = 1'b1;
                    end else begin
                        note_idx_next = note_idx_reg + IDX_W'(1);
                    end
                end
            end

            GAP: begin
                ms_cnt_next = ms_tick ? '0 : ms_cnt_reg + MS_W'(1);
                ms_num_next = ms_tick ? ms_num_reg + LEN_W'(1) : ms_num_reg;
                if (period_end) begin
                    ms_cnt_next = '0;
                    ms_num_next = '0;
                    state_next  = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.BUZZER     = buzzer_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.active_src = (state_reg == PLAY) ? src_reg : SRC_NONE;
    assign bus.done       = done_reg;
endmodule

// File: tb/tb_buzzer_scheduler.sv
// tb_buzzer_scheduler
// Directed scenarios plus a randomized request phase for buzzer_scheduler.
// A pattern-level reference model predicts each played pattern (source,
// length, normal completion); a negedge monitor reconstructs patterns from
// the DUT outputs and compares them against the expected queue.
module tb_buzzer_scheduler;
    localparam int MS           = 10;
    localparam int HALF_HI      = 5;
    localparam int HALF_LO      = 10;
    localparam int KEY_MS       = 2;
    localparam int OPEN_NOTE_MS = 3;
    localparam int ALARM_MS     = 2;
    localparam int ALARM_PAIRS  = 2;
    localparam int GAP_MS       = 1;
    localparam int GAP_CYC      = GAP_MS * MS;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    buzzer_scheduler_if bus ();

    buzzer_scheduler #(
        .CLK_HZ      (10000),
        .HI_HZ       (1000),
        .LO_HZ       (500),
        .KEY_MS      (KEY_MS),
        .OPEN_NOTE_MS(OPEN_NOTE_MS),
        .ALARM_MS    (ALARM_MS),
        .ALARM_PAIRS (ALARM_PAIRS),
        .GAP_MS      (GAP_MS)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int src;
        int len;
        bit done;
    } pat_t;

    pat_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- pattern arithmetic ----------------
    function automatic int note_cycles(input int src);
        case (src)
            1:       return KEY_MS * MS;
            2:       return OPEN_NOTE_MS * MS;
            default: return ALARM_MS * MS;
        endcase
    endfunction

    function automatic int note_count(input int src);
        case (src)
            1:       return 1;
            2:       return 2;
            default: return 2 * ALARM_PAIRS;
        endcase
    endfunction

    function automatic int pat_cycles(input int src);
        return note_cycles(src) * note_count(src);
    endfunction

    function automatic bit exp_buzzer(input int src, input int off);
        int nc, note, pos, half;
        bit hi;
        nc   = note_cycles(src);
        note = off / nc;
        pos  = off % nc;
        case (src)
            1:       hi = 1'b1;
            2:       hi = (note == 1);
            default: hi = ((note % 2) == 0);
        endcase
        half = hi ? HALF_HI : HALF_LO;
        return ((pos / half) % 2) == 1;
    endfunction

    // ---------------- reference model ----------------
    int       m_mode = 0;          // 0 idle, 1 playing, 2 gap
    int       m_src  = 0;
    int       m_rem  = 0;          // cycles left in current play/gap
    bit [3:0] m_pend = '0;         // indexed by source code
    int       m_done_total = 0;

    function automatic int m_top();
        if (m_pend[3]) return 3;
        if (m_pend[2]) return 2;
        if (m_pend[1]) return 1;
        return 0;
    endfunction

    task automatic push_exp(input int src, input int len, input bit done);
        pat_t p;
        p.src  = src;
        p.len  = len;
        p.done = done;
        exp_q.push_back(p);
    endtask

    // Advances the model across one clock edge with the requests sampled there.
    task automatic model_step(input bit k, input bit o, input bit f);
        int s;
        if (!RESET) begin
            m_mode = 0;
            m_pend = '0;
            return;
        end
        case (m_mode)
            0: begin
                s = m_top();
                if (s != 0) begin
                    m_pend[s] = 1'b0;
                    m_src     = s;
                    m_mode    = 1;
                    m_rem     = pat_cycles(s);
                end
            end
            1: begin
                s = m_top();
`ifdef BUZZER_PREEMPT_EN
                if (s > m_src) begin
                    push_exp(m_src, pat_cycles(m_src) - m_rem + 1, 1'b0);
                    m_pend[s] = 1'b0;
                    m_src     = s;
                    m_rem     = pat_cycles(s);
                end else
`endif
                begin
                    m_rem--;
                    if (m_rem == 0) begin
                        push_exp(m_src, pat_cycles(m_src), 1'b1);
                        m_done_total++;
                        m_mode = 2;
                        m_rem  = GAP_CYC;
                    end
                end
            end
            default: begin
                m_rem--;
                if (m_rem == 0) m_mode = 0;
            end
        endcase
        m_pend[1] = m_pend[1] | k;
        m_pend[2] = m_pend[2] | o;
        m_pend[3] = m_pend[3] | f;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit k, input bit o, input bit f);
        bus.req_key    = k;
        bus.req_open   = o;
        bus.req_freeze = f;
        @(posedge CLK);
        #1;
        model_step(k, o, f);
        bus.req_key    = 1'b0;
        bus.req_open   = 1'b0;
        bus.req_freeze = 1'b0;
    endtask

    task automatic assert_reset();
        RESET = 1'b0;
        if (m_mode == 1 && pat_cycles(m_src) - m_rem > 0)
            push_exp(m_src, pat_cycles(m_src) - m_rem, 1'b0);
        m_mode = 0;
        m_pend = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_mode != 0 || m_pend != 0) && n < 5000) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: model still busy after %0d cycles", n);
        end
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        check("drain_busy", bus.busy, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit in_pat = 0;
    bit in_gap = 0;
    int pat_src = 0, pat_len = 0, pat_bz_err = 0;
    int gap_len = 0, gap_bz_err = 0, idle_bz_err = 0;
    int pat_seen = 0, done_seen = 0;

    initial begin : monitor
        int   cur;
        bit   ended;
        pat_t e;
        forever begin
            @(negedge CLK);
            cur   = int'(bus.active_src);
            ended = 1'b0;
            if (bus.done) done_seen++;
            if (in_pat && cur != pat_src) begin
                ended  = 1'b1;
                in_pat = 1'b0;
                pat_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pattern_src", pat_src, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pattern_src", pat_src, e.src);
                    check("pattern_len", pat_len, e.len);
                    check("pattern_done", int'(bus.done), int'(e.done));
                    check("pattern_buzzer_errs", pat_bz_err, 0);
                end
                if (bus.done) begin
                    in_gap     = 1'b1;
                    gap_len    = 0;
                    gap_bz_err = 0;
                end
            end
            if (!ended && bus.done) check("spurious_done", int'(bus.done), 0);
            if (in_gap) begin
                if (RESET && bus.busy && cur == 0) begin
                    gap_len++;
                    if (bus.BUZZER) gap_bz_err++;
                end else begin
                    in_gap = 1'b0;
                    if (RESET) begin
                        check("gap_len", gap_len, GAP_CYC);
                        check("gap_buzzer_errs", gap_bz_err, 0);
                    end
                end
            end
            if (cur != 0 && !in_pat) begin
                in_pat     = 1'b1;
                pat_src    = cur;
                pat_len    = 0;
                pat_bz_err = 0;
            end
            if (in_pat) begin
                if (bus.BUZZER !== exp_buzzer(pat_src, pat_len)) pat_bz_err++;
                pat_len++;
            end else if (!in_gap && bus.BUZZER) begin
                idle_bz_err++;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin : stim
        int p0, d0;
        bus.req_key    = 1'b0;
        bus.req_open   = 1'b0;
        bus.req_freeze = 1'b0;
        RESET          = 1'b0;

        // 1: requests during reset are ignored
        for (int i = 0; i < 6; i++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("rst_buzzer", bus.BUZZER, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_src", bus.active_src, 0);
        check("rst_done", bus.done, 0);
        RESET = 1'b1;
        repeat (20) tick(1'b0, 1'b0, 1'b0);
        check("post_rst_busy", bus.busy, 0);

        // 2: single key click, start latency
        tick(1'b1, 1'b0, 1'b0);
        check("key_busy_t1", bus.busy, 0);
        tick(1'b0, 1'b0, 1'b0);
        check("key_busy_t2", bus.busy, 1);
        check("key_src_t2", bus.active_src, 1);
        drain();

        // 3: simultaneous requests -> freeze, open, key
        p0 = pat_seen;
        d0 = done_seen;
        tick(1'b1, 1'b1, 1'b1);
        drain();
        check("triple_patterns", pat_seen - p0, 3);
        check("triple_dones", done_seen - d0, 3);

        // 4: freeze arrives while open plays
        tick(1'b0, 1'b1, 1'b0);
        repeat (16) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
`ifdef BUZZER_PREEMPT_EN
        check("preempt_src", bus.active_src, 3);
`else
        check("no_preempt_src", bus.active_src, 2);
`endif
        drain();

        // 5: repeated key requests during one key pattern -> one replay
        p0 = pat_seen;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        drain();
        check("key_replay_patterns", pat_seen - p0, 2);

        // 6: reset mid freeze note
        tick(1'b0, 1'b0, 1'b1);
        repeat (8) tick(1'b0, 1'b0, 1'b0);
        check("pre_reset_buzzer", bus.BUZZER, 1);
        assert_reset();
        #1;
        check("mid_reset_buzzer", bus.BUZZER, 0);
        check("mid_reset_busy", bus.busy, 0);
        check("mid_reset_src", bus.active_src, 0);
        for (int i = 0; i < 3; i++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        RESET = 1'b1;
        repeat (30) tick(1'b0, 1'b0, 1'b0);
        check("after_reset_idle", bus.busy, 0);

        // randomized request traffic
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 59) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 99) == 0);
        drain();

        check("queue_empty", exp_q.size(), 0);
        check("done_total", done_seen, m_done_total);
        check("idle_buzzer_errs", idle_bz_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
